// File: rtl/uart_pkg.sv
// Shared encodings for the buffered UART transmitter: parity modes, the frame
// FSM states and the occupancy-width helper used by the FIFO and the top level.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count. Pushes while full and pops while
// empty are ignored; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and leave LSB-first on TX
// framed as start, DATA_BITS data, optional parity and one or two stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic [DATA_BITS-1:0]             data_in,
  input  logic                             en_data_in,
  input  logic [1:0]                       parity,
  input  logic                             stop2,
  output logic                             TX,
  output logic                             rdy,
  output logic                             busy,
  output logic                             overflow,
  output logic [level_w(FIFO_DEPTH)-1:0]   level,
  output logic [2:0]                       state_dbg_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int LW = level_w(FIFO_DEPTH);

  // Write handshake: a word is taken on any rising edge where en_data_in and
  // rdy are both high; en_data_in while rdy is low drops the word and raises
  // overflow for one cycle. There is no back-pressure beyond rdy itself.

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop2_q, stop2_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q;
  logic                   ovf_q;
  logic                   bit_end;
  logic                   load;

  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LW-1:0]          fifo_level;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (en_data_in),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;
    timer_d    = (state_q == ST_IDLE || bit_end) ? '0 : timer_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame options are captured with the word so later input changes cannot
    // disturb a frame already on the line.
    if (load) begin
      fifo_pop  = 1'b1;
      shreg_d   = fifo_rdata;
      par_en_d  = (parity == PAR_EVEN) || (parity == PAR_ODD);
      par_bit_d = (^fifo_rdata) ^ (parity == PAR_ODD);
      stop2_d   = stop2;
      state_d   = ST_START;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != ST_IDLE);
      ovf_q      <= en_data_in & fifo_full;
    end
  end

  assign TX          = tx_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign level       = fifo_level;
  assign rdy         = ~fifo_full;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8-bit instance checked through a frame-decoding
// scoreboard, and a 5-bit instance checked bit by bit against a frame model.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data8;
  logic       en8;
  logic [4:0] data5;
  logic       en5;
  logic [1:0] parity;
  logic       stop2;

  logic       tx8, rdy8, busy8, ovf8;
  logic [2:0] level8, st8;
  logic       tx5, rdy5, busy5, ovf5;
  logic [2:0] level5, st5;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut8 (
    .clk(clk), .res(res), .data_in(data8), .en_data_in(en8), .parity(parity),
    .stop2(stop2), .TX(tx8), .rdy(rdy8), .busy(busy8), .overflow(ovf8),
    .level(level8), .state_dbg_o(st8)
  );

  uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut5 (
    .clk(clk), .res(res), .data_in(data5), .en_data_in(en5), .parity(parity),
    .stop2(stop2), .TX(tx5), .rdy(rdy5), .busy(busy5), .overflow(ovf5),
    .level(level5), .state_dbg_o(st5)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];   // {stop2, parity[1:0], 1'b0, data[7:0]}
  bit          mon_en = 1'b0;
  bit          mon_active = 1'b0;
  logic        last_par = 1'b0;
  int          run8 = 0, last_busy8 = 0;
  int          run5 = 0, last_busy5 = 0;
  int          ovf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (res) begin
      run8 <= 0;
      run5 <= 0;
    end else begin
      if (busy8 === 1'b1) run8 <= run8 + 1;
      else if (run8 != 0) begin last_busy8 <= run8; run8 <= 0; end
      if (busy5 === 1'b1) run5 <= run5 + 1;
      else if (run5 != 0) begin last_busy5 <= run5; run5 <= 0; end
      if (ovf8 === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write8(input logic [7:0] d, input bit accept);
    data8 = d;
    en8   = 1'b1;
    if (accept) exp_q.push_back({stop2, parity, 1'b0, d});
    @(posedge clk);
    #1 en8 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy8 || busy5 || level8 != 0 || level5 != 0 || mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n >= budget, 0);
    #1;
  endtask

  // ---------------- serial monitor for dut8 ----------------
  task automatic rx_frame();
    logic [11:0] e;
    logic [8:0]  d;
    logic        pb;
    int          bad;
    int          nstop;
    check("rx_expected_frame", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'h000;
    bad = 0;
    d   = '0;
    repeat (CPB - 1) begin @(negedge clk); if (tx8 !== 1'b0) bad++; end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      d[b] = tx8;
      repeat (CPB - 1) begin @(negedge clk); if (tx8 !== d[b]) bad++; end
    end
    if (e[10:9] == 2'b01 || e[10:9] == 2'b10) begin
      @(negedge clk);
      pb = tx8;
      repeat (CPB - 1) begin @(negedge clk); if (tx8 !== pb) bad++; end
      check("rx_parity", pb, (^e[7:0]) ^ (e[10:9] == 2'b10));
      last_par = pb;
    end
    nstop = e[11] ? 2 * CPB : CPB;
    for (int i = 0; i < nstop; i++) begin
      @(negedge clk);
      if (tx8 !== 1'b1) bad++;
    end
    check("rx_data", d, e[8:0]);
    check("rx_bit_shape", bad, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !res && tx8 === 1'b0) begin
        mon_active = 1'b1;
        rx_frame();
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          peak;
    int          ovf_base;
    int          lows;
    int          busy_seen;
    bit          saw_rdy_low;
    logic [4:0]  d5;
    logic [7:0]  exp_bits;
    logic [7:0]  got_bits;

    data8 = '0; en8 = 1'b0; data5 = '0; en5 = 1'b0; parity = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx8, 1);
    check("rst_rdy", rdy8, 1);
    check("rst_busy", busy8, 0);
    check("rst_overflow", ovf8, 0);
    check("rst_level", level8, 0);
    check("rst_state", st8, 0);
    check("rst_tx5", tx5, 1);
    res = 1'b0;
    mon_en = 1'b1;

    // basic 8N1 frame and first-word latency
    @(negedge clk);
    write8(8'h0a, 1'b1);
    @(negedge clk);
    check("lat_level_after_write", level8, 1);
    check("lat_tx_before_pop", tx8, 1);
    check("lat_busy_before_pop", busy8, 0);
    @(negedge clk);
    check("lat_tx_start", tx8, 0);
    check("lat_busy_start", busy8, 1);
    check("lat_level_after_pop", level8, 0);
    wait_drain(200);
    check("basic_frame_len", last_busy8, 40);
    check("basic_sb_empty", exp_q.size(), 0);

    // even then odd parity
    parity = 2'b01;
    @(negedge clk);
    write8(8'h0a, 1'b1);
    wait_drain(200);
    check("even_frame_len", last_busy8, 44);
    check("even_par_bit", last_par, 0);
    parity = 2'b10;
    @(negedge clk);
    write8(8'h0a, 1'b1);
    wait_drain(200);
    check("odd_frame_len", last_busy8, 44);
    check("odd_par_bit", last_par, 1);
    parity = 2'b00;

    // two stop bits
    stop2 = 1'b1;
    @(negedge clk);
    write8(8'h0a, 1'b1);
    wait_drain(200);
    check("stop2_frame_len", last_busy8, 44);
    stop2 = 1'b0;

    // overflow and back-to-back frames
    ovf_base = ovf_cnt;
    peak = 0;
    saw_rdy_low = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      write8(8'(i), i <= 5);
      if (int'(level8) > peak) peak = int'(level8);
      if (rdy8 === 1'b0) saw_rdy_low = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("ovf_level_peak", peak, 4);
    check("ovf_rdy_dropped", saw_rdy_low, 1);
    check("ovf_pulse_count", ovf_cnt - ovf_base, 1);
    wait_drain(600);
    check("b2b_busy_run", last_busy8, 200);
    check("b2b_sb_empty", exp_q.size(), 0);
    check("b2b_rdy_back", rdy8, 1);

    // reset mid-frame with a second word queued
    mon_en = 1'b0;
    @(negedge clk);
    write8(8'ha5, 1'b0);
    write8(8'h3c, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (tx8 !== 1'b0 && n < 20);
    check("rst_mid_start_seen", n < 20, 1);
    repeat (4 * CPB + 1) @(negedge clk);
    check("rst_mid_queued", level8, 1);
    #1 res = 1'b1;
    #1;
    check("rst_mid_tx_async", tx8, 1);
    check("rst_mid_busy", busy8, 0);
    check("rst_mid_level", level8, 0);
    check("rst_mid_rdy", rdy8, 1);
    @(negedge clk);
    res = 1'b0;
    mon_en = 1'b1;
    lows = 0;
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx8 !== 1'b1) lows++;
      if (busy8 !== 1'b0) busy_seen++;
    end
    check("rst_mid_no_resume_tx", lows, 0);
    check("rst_mid_no_resume_busy", busy_seen, 0);

    // narrow 5-bit frame with even parity
    parity = 2'b01;
    d5 = 5'h1f;
    exp_bits = {1'b1, ^d5, d5, 1'b0};
    got_bits = '0;
    @(negedge clk);
    data5 = d5;
    en5 = 1'b1;
    @(posedge clk);
    #1 en5 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (tx5 !== 1'b0 && n < 20);
    check("n5_start_seen", n < 20, 1);
    for (int c = 0; c < 8 * CPB; c++) begin
      if (c % CPB == 1) got_bits[c / CPB] = tx5;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) check($sformatf("n5_bit%0d", i), got_bits[i], exp_bits[i]);
    wait_drain(200);
    check("n5_frame_len", last_busy5, 32);
    parity = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
